// File: rtl/fft_cooley_tukey_helpers_serializer.sv
// Output-end serializer for the Cooley-Tukey FFT datapath.
// Captures one full frame of SIZE_FFT complex points presented in parallel
// (per-lane val/rdy), then emits it one point per cycle on a single val/rdy
// stream, optionally in bit-reversed index order.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   recv_real/imag    per-lane input words        [SIZE_FFT][BIT_WIDTH]
//   recv_val/rdy      per-lane handshake (rdy identical on all lanes)
//   send_real/imag    serial output words
//   send_val/rdy      serial handshake
//   send_last         marks the final point of a frame

// One buffer slot: holds a complex point, loaded on frame capture.
module fft_cooley_tukey_helpers_serializer_lane #(
  parameter int BIT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [BIT_WIDTH-1:0] d_real,
  input  logic [BIT_WIDTH-1:0] d_imag,
  output logic [BIT_WIDTH-1:0] q_real,
  output logic [BIT_WIDTH-1:0] q_imag
);
  always_ff @(posedge clk) begin
    if (reset) begin
      q_real <= '0;
      q_imag <= '0;
    end else if (load) begin
      q_real <= d_real;
      q_imag <= d_imag;
    end
  end
endmodule

module fft_cooley_tukey_helpers_serializer #(
  parameter int BIT_WIDTH   = 32,
  parameter int SIZE_FFT    = 8,
  parameter int BIT_REVERSE = 0
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] recv_real,
  input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] recv_imaginary,
  input  logic [SIZE_FFT-1:0]                recv_val,
  output logic [SIZE_FFT-1:0]                recv_rdy,
  output logic [BIT_WIDTH-1:0]               send_real,
  output logic [BIT_WIDTH-1:0]               send_imaginary,
  output logic                               send_val,
  input  logic                               send_rdy,
  output logic                               send_last
);
  localparam int IDX_W = $clog2(SIZE_FFT);
  localparam logic [IDX_W-1:0] LAST = IDX_W'(SIZE_FFT - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t           state, state_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [IDX_W-1:0] idx_rev, rd_idx;
  logic             capture;

  logic [BIT_WIDTH-1:0] mem_real [SIZE_FFT];
  logic [BIT_WIDTH-1:0] mem_imag [SIZE_FFT];

  // Only a fully valid input array is captured; partial arrays are ignored.
  assign capture = (state == IDLE) && (&recv_val);

  for (genvar i = 0; i < SIZE_FFT; i++) begin : g_lane
    fft_cooley_tukey_helpers_serializer_lane #(.BIT_WIDTH(BIT_WIDTH)) u_lane (
      .clk    (clk),
      .reset  (reset),
      .load   (capture),
      .d_real (recv_real[i]),
      .d_imag (recv_imaginary[i]),
      .q_real (mem_real[i]),
      .q_imag (mem_imag[i])
    );
  end

  for (genvar b = 0; b < IDX_W; b++) begin : g_rev
    assign idx_rev[b] = idx[IDX_W-1-b];
  end

  assign rd_idx         = (BIT_REVERSE != 0) ? idx_rev : idx;
  assign send_real      = mem_real[rd_idx];
  assign send_imaginary = mem_imag[rd_idx];

  // rdy is a pure function of state and reset so upstream never sees a
  // combinational path from its own valid.
  assign recv_rdy  = {SIZE_FFT{(state == IDLE) && !reset}};
  assign send_val  = (state == SEND) && !reset;
  assign send_last = send_val && (idx == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Leaving SEND always passes through IDLE for a cycle, so a new capture
  // can never coincide with the final send handshake.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: if (capture) begin
        state_nxt = SEND;
        idx_nxt   = '0;
      end
      SEND: if (send_rdy) begin
        if (idx == LAST) begin
          state_nxt = IDLE;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        idx_nxt   = '0;
      end
    endcase
  end
endmodule
